// File: rtl/ppi_mirror_pkg.sv
// Shared constants and types for the MSX PPI write mirror.
// Holds the port addresses, reset values, Port C bit positions and the address decoder.
package ppi_mirror_pkg;

  localparam logic [7:0] PPI_PORT_A = 8'hA8;
  localparam logic [7:0] PPI_PORT_B = 8'hA9;
  localparam logic [7:0] PPI_PORT_C = 8'hAA;
  localparam logic [7:0] PPI_CTRL   = 8'hAB;

  localparam logic [7:0] PRIMARY_SLOT_RST = 8'h00;
  localparam logic [7:0] PORT_C_RST       = 8'h00;

  localparam int MOTOR_OFF    = 4;
  localparam int CAS_WRITE    = 5;
  localparam int CAPS_LED_OFF = 6;
  localparam int CLICK_SOUND  = 7;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PORT_A,
    SEL_PORT_B,
    SEL_PORT_C,
    SEL_CTRL
  } ppi_sel_e;

  // Only the low address byte takes part in I/O decode.
  function automatic ppi_sel_e decode_port(input logic [7:0] addr);
    ppi_sel_e sel;
    case (addr)
      PPI_PORT_A: sel = SEL_PORT_A;
      PPI_PORT_B: sel = SEL_PORT_B;
      PPI_PORT_C: sel = SEL_PORT_C;
      PPI_CTRL:   sel = SEL_CTRL;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ppi_mirror_port_c.sv
// Port C shadow register: full-byte write from 0xAA and single-bit set/reset from 0xAB.
// A control word with bit 7 set is a mode word and leaves the register untouched.
module ppi_mirror_port_c
  import ppi_mirror_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       i_wr_full,
  input  logic       i_wr_bsr,
  input  logic [7:0] i_data,
  output logic [7:0] o_port_c
);

  logic [7:0] r_port_c;
  logic [7:0] w_port_c_nxt;

  always_comb begin
    w_port_c_nxt = r_port_c;
    if (i_wr_full) begin
      w_port_c_nxt = i_data;
    end else if (i_wr_bsr && !i_data[7]) begin
      w_port_c_nxt[i_data[3:1]] = i_data[0];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_port_c <= PORT_C_RST;
    end else begin
      r_port_c <= w_port_c_nxt;
    end
  end

  assign o_port_c = r_port_c;

endmodule

// File: rtl/ppi_mirror.sv
// Write-only mirror of the MSX 8255 PPI: snoops I/O writes to Port A and Port C.
// Define PPI_MIRROR_BSR_EN to honour bit set/reset writes to the control port (0xAB).
module ppi_mirror
  import ppi_mirror_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] bus_address,
  output logic        bus_io_cs,
  output logic        bus_memory_cs,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic        bus_io,
  input  logic        bus_memory,
  output logic [7:0]  primary_slot,
  output logic [3:0]  key_matrix_row,
  output logic        motor_off,
  output logic        cas_write,
  output logic        caps_led_off,
  output logic        click_sound,
  input  logic [7:0]  key_matrix_column
);

  logic       w_io_wr;
  ppi_sel_e   w_sel;
  logic       w_wr_a;
  logic       w_wr_c;
  logic       w_wr_bsr;
  logic [7:0] w_port_c;
  logic [7:0] r_primary_slot;
  logic       w_unused;

  assign bus_io_cs     = 1'b1;
  assign bus_memory_cs = 1'b0;

  assign w_io_wr = bus_write & bus_io & ~bus_memory;
  assign w_sel   = decode_port(bus_address[7:0]);
  assign w_wr_a  = w_io_wr && (w_sel == SEL_PORT_A);
  assign w_wr_c  = w_io_wr && (w_sel == SEL_PORT_C);

`ifdef PPI_MIRROR_BSR_EN
  assign w_wr_bsr = w_io_wr && (w_sel == SEL_CTRL);
`else
  assign w_wr_bsr = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_primary_slot <= PRIMARY_SLOT_RST;
    end else if (w_wr_a) begin
      r_primary_slot <= bus_write_data;
    end
  end

  ppi_mirror_port_c u_port_c (
    .clk       (clk),
    .n_reset   (n_reset),
    .i_wr_full (w_wr_c),
    .i_wr_bsr  (w_wr_bsr),
    .i_data    (bus_write_data),
    .o_port_c  (w_port_c)
  );

  assign primary_slot   = r_primary_slot;
  assign key_matrix_row = w_port_c[3:0];
  assign motor_off      = w_port_c[MOTOR_OFF];
  assign cas_write      = w_port_c[CAS_WRITE];
  assign caps_led_off   = w_port_c[CAPS_LED_OFF];
  assign click_sound    = w_port_c[CLICK_SOUND];

  // Read strobe, Port B key data and the high address byte have no function here.
  assign w_unused = ^{bus_read, key_matrix_column, bus_address[15:8]};

endmodule

// File: tb/tb_ppi_mirror.sv
// Scoreboard bench for ppi_mirror: stimulus pushes expected register images, a negedge monitor compares.
// Honours PPI_MIRROR_BSR_EN the same way as the design build.
module tb_ppi_mirror;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] bus_address;
  logic        bus_io_cs;
  logic        bus_memory_cs;
  logic [7:0]  bus_write_data;
  logic        bus_read;
  logic        bus_write;
  logic        bus_io;
  logic        bus_memory;
  logic [7:0]  primary_slot;
  logic [3:0]  key_matrix_row;
  logic        motor_off;
  logic        cas_write;
  logic        caps_led_off;
  logic        click_sound;
  logic [7:0]  key_matrix_column;

  logic [7:0]  w_pc;
  assign w_pc = {click_sound, caps_led_off, cas_write, motor_off, key_matrix_row};

  typedef struct packed {
    logic [7:0] slot;
    logic [7:0] pc;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_slot;
  logic [7:0] m_pc;

  always #5 clk = ~clk;

  ppi_mirror dut (
    .clk               (clk),
    .n_reset           (n_reset),
    .bus_address       (bus_address),
    .bus_io_cs         (bus_io_cs),
    .bus_memory_cs     (bus_memory_cs),
    .bus_write_data    (bus_write_data),
    .bus_read          (bus_read),
    .bus_write         (bus_write),
    .bus_io            (bus_io),
    .bus_memory        (bus_memory),
    .primary_slot      (primary_slot),
    .key_matrix_row    (key_matrix_row),
    .motor_off         (motor_off),
    .cas_write         (cas_write),
    .caps_led_off      (caps_led_off),
    .click_sound       (click_sound),
    .key_matrix_column (key_matrix_column)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the PPI as seen from the bus, one byte per mirrored port.
  task automatic model_write(input logic [15:0] a, input logic [7:0] d,
                             input logic wr, input logic io, input logic mem);
    if (wr && io && !mem) begin
      if (a[7:0] == 8'hA8) m_slot = d;
      else if (a[7:0] == 8'hAA) m_pc = d;
`ifdef PPI_MIRROR_BSR_EN
      else if (a[7:0] == 8'hAB && d[7] == 1'b0) m_pc[d[3:1]] = d[0];
`endif
    end
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d,
                           input logic wr, input logic io, input logic mem, input logic rd);
    exp_t e;
    bus_address    = a;
    bus_write_data = d;
    bus_write      = wr;
    bus_io         = io;
    bus_memory     = mem;
    bus_read       = rd;
    key_matrix_column = 8'($urandom);
    @(posedge clk);
    model_write(a, d, wr, io, mem);
    e.slot = m_slot;
    e.pc   = m_pc;
    q.push_back(e);
    #1;
    bus_write = 1'b0;
    bus_read  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check8("primary_slot", primary_slot, e.slot);
      check8("port_c", w_pc, e.pc);
      check8("bus_io_cs", {7'd0, bus_io_cs}, 8'd1);
      check8("bus_memory_cs", {7'd0, bus_memory_cs}, 8'd0);
    end
  end

  logic [15:0] a_list [5];
  logic [7:0]  d_list [5];

  initial begin
    a_list = '{16'h00A8, 16'hCDA8, 16'h05A8, 16'h43A8, 16'hABA8};
    d_list = '{8'h12, 8'hAB, 8'h55, 8'h93, 8'h0F};
    n_reset = 1'b0;
    bus_address = 16'h0; bus_write_data = 8'h0; bus_read = 1'b0;
    bus_write = 1'b0; bus_io = 1'b0; bus_memory = 1'b0; key_matrix_column = 8'h0;
    m_slot = 8'h00;
    m_pc   = 8'h00;

    #12;
    check8("rst_io_cs", {7'd0, bus_io_cs}, 8'd1);
    check8("rst_memory_cs", {7'd0, bus_memory_cs}, 8'd0);
    check8("rst_primary_slot", primary_slot, 8'h00);
    check8("rst_port_c", w_pc, 8'h00);
    @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) bus_cycle(a_list[i], d_list[i], 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00A8, 8'hDA, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bus_cycle(a_list[i], d_list[i], 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      bus_cycle({8'($urandom), 8'hAA}, d_list[i], 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00AA, 8'hAD, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      bus_cycle({8'($urandom), 8'hAA}, d_list[i], 1'b1, 1'b0, 1'b1, 1'b0);

    // Port B, reads, and I/O with memory also set must all be ignored.
    bus_cycle(16'h00A9, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00A8, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
    bus_cycle(16'h00AA, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0);

    bus_cycle(16'h00AA, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00AB, 8'h0B, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00AB, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00AB, 8'h82, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h12AB, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00AB, 8'h0E, 1'b1, 1'b0, 1'b1, 1'b0);

    // Held strobe: same value rewritten on successive edges.
    for (int i = 0; i < 3; i++) bus_cycle(16'h00A8, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);

    bus_cycle(16'h00A8, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 n_reset = 1'b0;
    #1;
    check8("async_rst_primary_slot", primary_slot, 8'h00);
    check8("async_rst_port_c", w_pc, 8'h00);
    m_slot = 8'h00;
    m_pc   = 8'h00;
    #1 n_reset = 1'b1;
    @(posedge clk);
    #1;
    bus_cycle(16'h00A8, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_cycle(16'h00AA, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [7:0] lo;
      logic [7:0] d;
      case ($urandom_range(0, 4))
        0: lo = 8'hA8;
        1: lo = 8'hA9;
        2: lo = 8'hAA;
        3: lo = 8'hAB;
        default: lo = 8'($urandom);
      endcase
      d = 8'($urandom);
      bus_cycle({8'($urandom), lo}, d, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                1'($urandom));
    end

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
